// File: rtl/adder_pkg.sv
// Shared types, constants and helper functions for the chunked add/subtract unit.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Widest WIDTH the saturation constant helpers can describe.
    localparam int MAX_WIDTH = 64;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] signed_max(input int width);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < width - 1; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] signed_min(input int width);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        r[width-1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/ripple_slice.sv
// CHUNK-bit ripple-carry slice built from a per-bit full-adder chain.
module ripple_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per clock through a shared ripple slice.
// Optional ADDSUB_SAT_EN clamps an overflowing result to the signed limit.
//
// state | meaning
// IDLE  | ready for an operand beat
// CALC  | computing slice k, carry held in c_q
// DONE  | result registered, waiting for out_ready
module chunked_addsub
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NCH = nchunk(WIDTH, CHUNK);
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_CALC = 2'(CALC);
    localparam logic [1:0] ST_DONE = 2'(DONE);

    if ((CHUNK < 1) || (WIDTH % CHUNK != 0) || (WIDTH > MAX_WIDTH)) begin : g_bad_cfg
        $error("chunked_addsub: WIDTH must be a multiple of CHUNK and at most MAX_WIDTH");
    end

    logic [1:0]       state_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic             c_q;
    logic             sub_q;
    logic [WIDTH-1:0] out_sum_q;
    logic             out_cout_q;
    logic             out_ovf_q;

    logic [CHUNK-1:0] sl_a;
    logic [CHUNK-1:0] sl_b;
    logic [CHUNK-1:0] sl_sum;
    logic             sl_cout;
    logic             sl_cmsb;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] result;
    logic             ovf_next;

    always_comb begin
        sl_a     = '0;
        sl_b     = '0;
        acc_next = acc_q;
        for (int i = 0; i < NCH; i++) begin
            if (k_q == KW'(i)) begin
                sl_a = a_q[i*CHUNK +: CHUNK];
                sl_b = b_q[i*CHUNK +: CHUNK];
                acc_next[i*CHUNK +: CHUNK] = sl_sum;
            end
        end
    end

    ripple_slice #(.CHUNK(CHUNK)) u_slice (
        .a     (sl_a),
        .b     (sl_b),
        .cin   (c_q),
        .sum   (sl_sum),
        .cout  (sl_cout),
        .c_msb (sl_cmsb)
    );

    // Only meaningful on the final slice, where the slice MSB is the word MSB.
    assign ovf_next = sl_cmsb ^ sl_cout;

`ifdef ADDSUB_SAT_EN
    localparam logic [MAX_WIDTH-1:0] SMAX_FULL = signed_max(WIDTH);
    localparam logic [MAX_WIDTH-1:0] SMIN_FULL = signed_min(WIDTH);
    localparam logic [WIDTH-1:0]     SMAX      = SMAX_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]     SMIN      = SMIN_FULL[WIDTH-1:0];

    assign result = !ovf_next ? acc_next : (a_q[WIDTH-1] ? SMIN : SMAX);
`else
    assign result = acc_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            c_q        <= 1'b0;
            sub_q      <= 1'b0;
            out_sum_q  <= '0;
            out_cout_q <= 1'b0;
            out_ovf_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_sub ? ~in_b : in_b;
                        c_q     <= in_cin ^ in_sub;
                        sub_q   <= in_sub;
                        k_q     <= '0;
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc_q <= acc_next;
                    c_q   <= sl_cout;
                    if (k_q == K_LAST) begin
                        k_q        <= '0;
                        out_sum_q  <= result;
                        out_cout_q <= sl_cout ^ sub_q;
                        out_ovf_q  <= ovf_next;
                        state_q    <= ST_DONE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Directed self-checking bench for chunked_addsub at WIDTH=16, CHUNK=4.
// Expected sums follow ADDSUB_SAT_EN when it is defined for the build.
module tb_chunked_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_sub;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        out_ovf;

    int tests = 0;
    int fails = 0;

    logic [15:0] r_sum;
    logic        r_cout;
    logic        r_ovf;
    int          r_lat;

`ifdef ADDSUB_SAT_EN
    localparam logic [15:0] EXP_ADD_OVF = 16'h7FFF;
    localparam logic [15:0] EXP_SUB_OVF = 16'h8000;
`else
    localparam logic [15:0] EXP_ADD_OVF = 16'h8000;
    localparam logic [15:0] EXP_SUB_OVF = 16'h7FFF;
`endif

    always #5 clk = ~clk;

    chunked_addsub #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    // Issue one beat from IDLE, scramble the inputs after acceptance, and wait for out_valid.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic cin);
        @(negedge clk);
        in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = 16'hDEAD; in_b = 16'hBEEF; in_sub = ~sub; in_cin = ~cin;
        r_lat = 0;
        while (out_valid !== 1'b1 && r_lat < 40) begin
            @(posedge clk); #1;
            r_lat++;
        end
        r_sum = out_sum; r_cout = out_cout; r_ovf = out_ovf;
    endtask

    task automatic ack_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0;
        #12;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        tests++; if (out_sum !== 16'h0000) begin fails++; $display("FAIL reset_sum got %h exp 0000", out_sum); end
        tests++; if (out_cout !== 1'b0) begin fails++; $display("FAIL reset_cout got %b exp 0", out_cout); end
        tests++; if (out_ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b exp 0", out_ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        run_op(16'h1234, 16'h0FCD, 1'b0, 1'b0);
        tests++; if (r_lat !== 4) begin fails++; $display("FAIL add_basic_latency got %0d exp 4", r_lat); end
        tests++; if (r_sum !== 16'h2201) begin fails++; $display("FAIL add_basic_sum got %h exp 2201", r_sum); end
        tests++; if (r_cout !== 1'b0) begin fails++; $display("FAIL add_basic_cout got %b exp 0", r_cout); end
        tests++; if (r_ovf !== 1'b0) begin fails++; $display("FAIL add_basic_ovf got %b exp 0", r_ovf); end
        ack_result();

        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        tests++; if (r_sum !== 16'h0000) begin fails++; $display("FAIL add_wrap_sum got %h exp 0000", r_sum); end
        tests++; if (r_cout !== 1'b1) begin fails++; $display("FAIL add_wrap_cout got %b exp 1", r_cout); end
        tests++; if (r_ovf !== 1'b0) begin fails++; $display("FAIL add_wrap_ovf got %b exp 0", r_ovf); end
        ack_result();

        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        tests++; if (r_sum !== EXP_ADD_OVF) begin fails++; $display("FAIL add_ovf_sum got %h exp %h", r_sum, EXP_ADD_OVF); end
        tests++; if (r_cout !== 1'b0) begin fails++; $display("FAIL add_ovf_cout got %b exp 0", r_cout); end
        tests++; if (r_ovf !== 1'b1) begin fails++; $display("FAIL add_ovf_ovf got %b exp 1", r_ovf); end
        ack_result();
    endtask

    task automatic test_sub();
        run_op(16'h0005, 16'h0007, 1'b1, 1'b0);
        tests++; if (r_lat !== 4) begin fails++; $display("FAIL sub_neg_latency got %0d exp 4", r_lat); end
        tests++; if (r_sum !== 16'hFFFE) begin fails++; $display("FAIL sub_neg_sum got %h exp FFFE", r_sum); end
        tests++; if (r_cout !== 1'b1) begin fails++; $display("FAIL sub_neg_borrow got %b exp 1", r_cout); end
        tests++; if (r_ovf !== 1'b0) begin fails++; $display("FAIL sub_neg_ovf got %b exp 0", r_ovf); end
        ack_result();

        run_op(16'h0005, 16'h0003, 1'b1, 1'b1);
        tests++; if (r_sum !== 16'h0001) begin fails++; $display("FAIL sub_bin_sum got %h exp 0001", r_sum); end
        tests++; if (r_cout !== 1'b0) begin fails++; $display("FAIL sub_bin_borrow got %b exp 0", r_cout); end
        tests++; if (r_ovf !== 1'b0) begin fails++; $display("FAIL sub_bin_ovf got %b exp 0", r_ovf); end
        ack_result();

        run_op(16'h8000, 16'h0001, 1'b1, 1'b0);
        tests++; if (r_sum !== EXP_SUB_OVF) begin fails++; $display("FAIL sub_ovf_sum got %h exp %h", r_sum, EXP_SUB_OVF); end
        tests++; if (r_cout !== 1'b0) begin fails++; $display("FAIL sub_ovf_borrow got %b exp 0", r_cout); end
        tests++; if (r_ovf !== 1'b1) begin fails++; $display("FAIL sub_ovf_ovf got %b exp 1", r_ovf); end
        ack_result();
    endtask

    task automatic test_backpressure();
        run_op(16'h0003, 16'h0004, 1'b0, 1'b0);
        tests++; if (r_sum !== 16'h0007) begin fails++; $display("FAIL bp_sum got %h exp 0007", r_sum); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h1111; in_sub = 1'b0; in_cin = 1'b1;
            @(posedge clk); #1;
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid cycle %0d got %b exp 1", i, out_valid); end
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready cycle %0d got %b exp 0", i, in_ready); end
            tests++; if (out_sum !== 16'h0007) begin fails++; $display("FAIL bp_hold_sum cycle %0d got %h exp 0007", i, out_sum); end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_in_ready got %b exp 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_out_valid got %b exp 0", out_valid); end
        @(posedge clk); #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_no_stale_accept got %b exp 1", in_ready); end
        tests++; if (out_sum !== 16'h0007) begin fails++; $display("FAIL bp_sum_after_ack got %h exp 0007", out_sum); end
    endtask

    task automatic test_back_to_back();
        int accepts;
        int results;
        int bad_sum;
        accepts = 0; results = 0; bad_sum = 0;
        @(negedge clk);
        in_a = 16'h0010; in_b = 16'h0020; in_sub = 1'b0; in_cin = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int e = 0; e < 18; e++) begin
            if (in_ready === 1'b1) accepts++;
            if (out_valid === 1'b1) begin
                results++;
                if (out_sum !== 16'h0030) bad_sum++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        tests++; if (accepts !== 3) begin fails++; $display("FAIL b2b_accepts got %0d exp 3", accepts); end
        tests++; if (results !== 3) begin fails++; $display("FAIL b2b_results got %0d exp 3", results); end
        tests++; if (bad_sum !== 0) begin fails++; $display("FAIL b2b_sum_errors got %0d exp 0", bad_sum); end
        @(posedge clk); #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_idle_after got %b exp 1", in_ready); end
    endtask

    task automatic test_reset_mid_op();
        int seen;
        @(negedge clk);
        in_a = 16'h1111; in_b = 16'h2222; in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b exp 0", in_ready); end
        rst_n = 1'b0;
        #1;
        tests++; if (out_sum !== 16'h0000) begin fails++; $display("FAIL rst_mid_sum got %h exp 0000", out_sum); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid got %b exp 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_in_ready got %b exp 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL rst_mid_stale_result got %0d valid cycles exp 0", seen); end
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0);
        tests++; if (r_lat !== 4) begin fails++; $display("FAIL rst_mid_new_latency got %0d exp 4", r_lat); end
        tests++; if (r_sum !== 16'h0002) begin fails++; $display("FAIL rst_mid_new_sum got %h exp 0002", r_sum); end
        ack_result();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
